// File: rtl/cmplx_mac_pipe.sv
// Three-stage pipelined complex multiplier / multiply-accumulator with valid/ready flow control.
// Supports plain product, product with conjugated B, and frame dot-product accumulation.
module cmplx_mac_pipe #(
    parameter int W        = 32,
    parameter int ACC_BITS = 8,
    localparam int OW      = 2*W + 1 + ACC_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_last,
    input  logic [1:0]           mode,
    input  logic signed [W-1:0]  ar,
    input  logic signed [W-1:0]  ai,
    input  logic signed [W-1:0]  br,
    input  logic signed [W-1:0]  bi,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic signed [OW-1:0] pr,
    output logic signed [OW-1:0] pi
);

    logic en;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // Stage 1: raw products; conjugation negates the bi products so -2**(W-1) stays exact
    logic signed [2*W-1:0] m_rr, m_ii, m_ri, m_ir;
    logic signed [2*W-1:0] p_rr, p_ii, p_ri, p_ir;
    logic                  v1, last1, accm1;

    always_comb begin
        m_rr = ar * br;
        m_ii = ai * bi;
        m_ri = ar * bi;
        m_ir = ai * br;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1    <= 1'b0;
            last1 <= 1'b0;
            accm1 <= 1'b0;
            p_rr  <= '0;
            p_ii  <= '0;
            p_ri  <= '0;
            p_ir  <= '0;
        end else if (en) begin
            v1    <= in_valid;
            last1 <= in_last;
            accm1 <= mode[1];
            p_rr  <= m_rr;
            p_ii  <= mode[0] ? -m_ii : m_ii;
            p_ri  <= mode[0] ? -m_ri : m_ri;
            p_ir  <= m_ir;
        end
    end

    // Stage 2: exact real/imag sums on 2W+1 bits
    logic signed [2*W:0] re_n, im_n;
    logic signed [2*W:0] re2, im2;
    logic                v2, last2, accm2;

    always_comb begin
        re_n = $signed({p_rr[2*W-1], p_rr}) - $signed({p_ii[2*W-1], p_ii});
        im_n = $signed({p_ri[2*W-1], p_ri}) + $signed({p_ir[2*W-1], p_ir});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v2    <= 1'b0;
            last2 <= 1'b0;
            accm2 <= 1'b0;
            re2   <= '0;
            im2   <= '0;
        end else if (en) begin
            v2    <= v1;
            last2 <= last1;
            accm2 <= accm1;
            re2   <= re_n;
            im2   <= im_n;
        end
    end

    // Stage 3: plain beats go straight out; frame beats fold into the accumulator until last
    logic signed [OW-1:0] re_x, im_x;
    logic signed [OW-1:0] acc_r, acc_i;

    always_comb begin
        re_x = {{ACC_BITS{re2[2*W]}}, re2};
        im_x = {{ACC_BITS{im2[2*W]}}, im2};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            pr        <= '0;
            pi        <= '0;
            acc_r     <= '0;
            acc_i     <= '0;
        end else if (en) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (v2) begin
                if (!accm2) begin
                    pr        <= re_x;
                    pi        <= im_x;
                    out_valid <= 1'b1;
                end else if (last2) begin
                    pr        <= acc_r + re_x;
                    pi        <= acc_i + im_x;
                    out_valid <= 1'b1;
                    out_last  <= 1'b1;
                    acc_r     <= '0;
                    acc_i     <= '0;
                end else begin
                    acc_r <= acc_r + re_x;
                    acc_i <= acc_i + im_x;
                end
            end
        end
    end

endmodule
